qam_symbol_mapper: RTL and testbench

- Upstream stage of the QAM modulator top level.
- Accepts a serial bitstream through a valid/ready handshake and packs it into 2-bit 4-QAM symbols.
- Drives the modulator's sign inputs, elojel_sin and elojel_cos, holding each symbol for exactly SYM_LEN carrier-sample clocks.
- Contains a one-symbol pending buffer so the source can run ahead of symbol timing.

---
 rtl/qam_pkg.sv | 17 +
 rtl/qam_bit_pair_assembler.sv | 57 +++++
 rtl/qam_symbol_mapper.sv | 125 ++++++++++++
 tb/tb_qam_symbol_mapper.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// qam_pkg: shared types and constants for the QAM symbol mapper.
// Holds the symbol struct, FSM state codes and default symbol length.
package qam_pkg;

  localparam int SYM_LEN_DEF = 64;

  typedef struct packed {
    logic sin_neg;
    logic cos_neg;
  } qam_sym_t;

  typedef logic [0:0] qam_state_t;

  localparam qam_state_t IDLE = 1'b0;
  localparam qam_state_t RUN  = 1'b1;

endpackage

// File: rtl/qam_bit_pair_assembler.sv
// qam_bit_pair_assembler: packs bit pairs into symbols plus a one-deep
// pending buffer; ports: bit handshake in, pend_* / sym_* to timing logic.
module qam_bit_pair_assembler
  import qam_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     bit_in,
  input  logic     bit_valid,
  output logic     bit_ready,
  input  logic     pend_pop,
  input  logic     fwd_take,
  output logic     pend_valid,
  output qam_sym_t pend_sym,
  output logic     sym_done,
  output qam_sym_t sym_new
);

  logic half_full;
  logic sin_bit;
  logic fire;
  logic pend_wr;

  // A completing bit with the buffer full would have nowhere to go.
  assign bit_ready = rst & ~(half_full & pend_valid);
  assign fire      = bit_valid & bit_ready;
  assign sym_done  = fire & half_full;

  assign sym_new.sin_neg = sin_bit;
  assign sym_new.cos_neg = bit_in;

  // A symbol taken straight to the outputs bypasses the buffer.
  assign pend_wr = sym_done & ~fwd_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_full  <= 1'b0;
      sin_bit    <= 1'b0;
      pend_valid <= 1'b0;
      pend_sym   <= '0;
    end else begin
      if (fire) begin
        half_full <= ~half_full;
        if (!half_full) begin
          sin_bit <= bit_in;
        end
      end
      if (pend_wr) begin
        pend_valid <= 1'b1;
        pend_sym   <= sym_new;
      end else if (pend_pop) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper: bit stream to 4-QAM signs, SYM_LEN clocks/symbol.
// Ports: bit_* handshake, elojel_sin/cos, tx_active, sym_strobe, underrun.
// Define QAM_DIFF_ENC_EN for differential encoding of the signs.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int CW      = $clog2(SYM_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic elojel_sin,
  output logic elojel_cos,
  output logic tx_active,
  output logic sym_strobe,
  output logic underrun
);

  qam_state_t    state;
  logic [CW-1:0] sym_cnt;
  qam_sym_t      out_sym;

  logic     pend_valid;
  logic     sym_done;
  logic     pend_pop;
  logic     fwd_take;
  logic     bnd;
  logic     load;
  qam_sym_t pend_sym;
  qam_sym_t sym_new;
  qam_sym_t nxt_sym;
  qam_sym_t nxt_out;

  qam_bit_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .pend_pop   (pend_pop),
    .fwd_take   (fwd_take),
    .pend_valid (pend_valid),
    .pend_sym   (pend_sym),
    .sym_done   (sym_done),
    .sym_new    (sym_new)
  );

  assign bnd = (state == RUN) &&
               (sym_cnt == CW'(SYM_LEN - 1));

  always_comb begin
    pend_pop = 1'b0;
    fwd_take = 1'b0;
    nxt_sym  = pend_sym;
    unique case (1'b1)
      (state == IDLE): begin
        pend_pop = pend_valid;
      end
      bnd: begin
        pend_pop = pend_valid;
        // Empty buffer: a pair finishing right now still makes it.
        fwd_take = ~pend_valid & sym_done;
        if (!pend_valid) begin
          nxt_sym = sym_new;
        end
      end
      default: begin
      end
    endcase
  end

  assign load = pend_pop | fwd_take;

`ifdef QAM_DIFF_ENC_EN
  // out_sym doubles as the previous transmitted sign per axis.
  assign nxt_out = nxt_sym ^ out_sym;
`else
  assign nxt_out = nxt_sym;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      out_sym    <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_strobe <= load;
      underrun   <= bnd & ~load;
      if (load) begin
        out_sym <= nxt_out;
      end
      unique case (state)
        IDLE: begin
          sym_cnt <= '0;
          if (load) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bnd) begin
            sym_cnt <= '0;
            if (!load) begin
              state <= IDLE;
            end
          end else begin
            sym_cnt <= sym_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign elojel_sin = out_sym.sin_neg;
  assign elojel_cos = out_sym.cos_neg;
  assign tx_active  = (state == RUN);

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// tb_qam_symbol_mapper: scoreboard bench, two mappers (SYM_LEN 64 and 4).
// Directed bit pairs push expected symbols; a monitor checks each strobe.
module tb_qam_symbol_mapper;

`ifdef QAM_DIFF_ENC_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn;
  logic [1:0] bi;
  logic [1:0] bv;
  logic [1:0] br;
  logic [1:0] es;
  logic [1:0] ec;
  logic [1:0] ta;
  logic [1:0] ss;
  logic [1:0] ur;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qam_symbol_mapper #(.SYM_LEN(64)) u_a (
    .clk        (clk),
    .rst        (rstn[0]),
    .bit_in     (bi[0]),
    .bit_valid  (bv[0]),
    .bit_ready  (br[0]),
    .elojel_sin (es[0]),
    .elojel_cos (ec[0]),
    .tx_active  (ta[0]),
    .sym_strobe (ss[0]),
    .underrun   (ur[0])
  );

  qam_symbol_mapper #(.SYM_LEN(4)) u_b (
    .clk        (clk),
    .rst        (rstn[1]),
    .bit_in     (bi[1]),
    .bit_valid  (bv[1]),
    .bit_ready  (br[1]),
    .elojel_sin (es[1]),
    .elojel_cos (ec[1]),
    .tx_active  (ta[1]),
    .sym_strobe (ss[1]),
    .underrun   (ur[1])
  );

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] q [2][$];
  logic [1:0] prev [2];
  logic [1:0] cur [2];
  logic       have [2];
  logic       pta [2];
  int         lst [2];
  int         lastx [2];
  int         nstrobe [2];
  int         nur [2];
  int         nblk [2];

  function automatic int lenof(input int d);
    return (d == 0) ? 64 : 4;
  endfunction

  function automatic logic [1:0] model(input int d,
                                       input logic [1:0] raw);
    return raw ^ (DIFF ? prev[d] : 2'b00);
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        have[d] = 1'b0;
        pta[d]  = 1'b0;
      end else begin
        if (ss[d]) begin
          check("strobe_expected", q[d].size() > 0, 1);
          if (q[d].size() > 0) begin
            cur[d] = q[d].pop_front();
            check("symbol", {es[d], ec[d]}, cur[d]);
          end
          if (pta[d])
            check("sym_spacing", cyc - lst[d], lenof(d));
          else
            check("restart_latency", cyc - lastx[d] - 1, 1);
          check("tx_active_run", ta[d], 1);
          have[d] = 1'b1;
          lst[d]  = cyc;
          nstrobe[d]++;
        end else if (ta[d] && have[d]) begin
          check("hold", {es[d], ec[d]}, cur[d]);
        end
        if (ur[d]) begin
          nur[d]++;
          check("underrun_at", cyc - lst[d], lenof(d));
          check("idle_after_underrun", ta[d], 0);
          if (have[d])
            check("keep_last", {es[d], ec[d]}, cur[d]);
        end
        pta[d] = ta[d];
      end
    end
  end

  task automatic send_bit(input int d, input logic b,
                          output int xc);
    int t;
    t = 0;
    @(negedge clk);
    bi[d] = b;
    bv[d] = 1'b1;
    while (!br[d] && t < 500) begin
      nblk[d]++;
      t++;
      @(negedge clk);
    end
    if (t >= 500) check("ready_timeout", br[d], 1);
    xc = cyc;
    @(posedge clk);
  endtask

  task automatic send_pair_exp(input int d, input logic a,
                               input logic b,
                               input logic [1:0] e);
    int x;
    send_bit(d, a, x);
    send_bit(d, b, x);
    lastx[d] = x;
    q[d].push_back(e);
    prev[d] = e;
  endtask

  task automatic send_pair(input int d, input logic a,
                           input logic b);
    send_pair_exp(d, a, b, model(d, {a, b}));
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    bv[d] = 1'b0;
  endtask

  task automatic wait_strobe(input int d);
    int t;
    t = 0;
    while (!ss[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("strobe_seen", ss[d], 1);
  endtask

  task automatic wait_ur(input int d, input int tgt);
    int t;
    t = 0;
    while (nur[d] < tgt && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("underrun_count", nur[d], tgt);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs;
    int k;
    int u;
    int x;
    logic [1:0] t6i [3];
    logic [1:0] t6e [3];
    rstn = 2'b00;
    bi   = 2'b00;
    bv   = 2'b00;
    for (int d = 0; d < 2; d++) begin
      prev[d] = 2'b00;    cur[d] = 2'b00;
      have[d] = 1'b0;     pta[d] = 1'b0;
      lst[d] = 0;         lastx[d] = 0;
      nstrobe[d] = 0;     nur[d] = 0;
      nblk[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_outs",
            {br[d], es[d], ec[d], ta[d], ss[d], ur[d]}, 0);
    rstn = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("ready_after_reset", br[d], 1);
      check("idle_after_reset", ta[d], 0);
    end

    // single pair, long symbol, then starvation
    send_pair(0, 1'b1, 1'b0);
    idle(0);
    wait_ur(0, 1);
    check("t1_strobes", nstrobe[0], 1);
    check("t1_idle", ta[0], 0);

    // continuous stream on the short-symbol mapper
    nblk[1] = 0;
    send_pair(1, 1'b1, 1'b1);
    send_pair(1, 1'b0, 1'b1);
    send_pair(1, 1'b0, 1'b0);
    idle(1);
    wait_ur(1, 1);
    check("t2_strobes", nstrobe[1], 3);
    check("t2_ready_blocked", nblk[1] > 0, 1);

    // second bit lands on the boundary edge with pending empty
    send_pair(1, 1'b1, 1'b0);
    send_bit(1, 1'b0, x);
    idle(1);
    wait_strobe(1);
    cs = cyc;
    while (cyc != cs + 3) @(negedge clk);
    bi[1] = 1'b1;
    bv[1] = 1'b1;
    @(posedge clk);
    q[1].push_back(model(1, 2'b01));
    prev[1] = model(1, 2'b01);
    idle(1);
    wait_ur(1, 2);
    check("t3_strobes", nstrobe[1], 5);

    // source stalls for 200 clocks, then resumes
    send_pair(0, 1'b0, 1'b1);
    idle(0);
    repeat (200) @(negedge clk);
    check("t4_one_underrun", nur[0], 2);
    send_pair(0, 1'b1, 1'b0);
    idle(0);
    wait_ur(0, 3);
    check("t4_strobes", nstrobe[0], 3);

    // async reset mid-symbol with a symbol pending
    send_pair(0, 1'b1, 1'b1);
    idle(0);
    wait_strobe(0);
    cs = cyc;
    send_pair(0, 1'b0, 1'b1);
    idle(0);
    while (cyc != cs + 30) @(negedge clk);
    rstn[0] = 1'b0;
    #1;
    check("async_reset",
          {br[0], es[0], ec[0], ta[0], ss[0], ur[0]}, 0);
    q[0].delete();
    prev[0] = 2'b00;
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    k = nstrobe[0];
    u = nur[0];
    repeat (100) @(negedge clk);
    check("t5_no_stale", nstrobe[0], k);
    check("t5_no_underrun", nur[0], u);
    send_pair(0, 1'b1, 1'b0);
    idle(0);
    wait_ur(0, u + 1);
    check("t5_strobes", nstrobe[0], k + 1);

    // pairs (1,0),(1,0),(0,1) from a fresh reset
    rstn[1] = 1'b0;
    repeat (2) @(negedge clk);
    rstn[1] = 1'b1;
    q[1].delete();
    prev[1] = 2'b00;
    t6i = '{2'b10, 2'b10, 2'b01};
`ifdef QAM_DIFF_ENC_EN
    t6e = '{2'b10, 2'b00, 2'b01};
`else
    t6e = '{2'b10, 2'b10, 2'b01};
`endif
    for (int i = 0; i < 3; i++) begin
      logic [1:0] p;
      p = t6i[i];
      send_pair_exp(1, p[1], p[0], t6e[i]);
    end
    idle(1);
    wait_ur(1, 3);
    check("t6_strobes", nstrobe[1], 8);
    check("t6_queue_empty", q[1].size(), 0);
    check("t0_queue_empty", q[0].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
